// File: rtl/cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-lookahead
// adder (hierarchical_CLA) between two requesters. The winner of a
// round-robin arbitration has its operands latched. They are then pushed
// through the CLA one nibble per cycle, LSB nibble first, and the full sum
// is returned on a valid/ready response port.
//
// Handshake semantics (all ports): a transfer happens on the rising clock
// edge where valid && ready are both high. Once raised, the producer holds
// valid and the payload stable until that edge. ready may depend
// combinationally on valid (reqN_ready does). rsp_ready is sampled only
// while rsp_valid is high.
//
// Optional feature macro: CLA_SEQ_SUB_EN adds req0_sub / req1_sub. When
// set, the operation becomes a - b: effective B = ~b, initial carry = 1,
// reqN_cin ignored, and rsp_cout = 1 means no borrow.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_* / req1_*           request ports (valid, ready, a, b, cin[, sub])
//   rsp_valid, rsp_ready      response handshake
//   rsp_id                    requester that owns the result
//   rsp_sum, rsp_cout         sum and carry out of bit WIDTH-1
//   rsp_ovf                   signed overflow (based on the effective B)
//   dbg_state                 current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder. All carries are formed from the
// generate/propagate terms and Cin directly, so no carry ripples here.
module hierarchical_CLA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
    S    = p ^ c[3:0];
    Cout = c[4];
  end
endmodule

module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             req0_sub,
`endif
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             req1_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [1:0]       dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // effective B (already inverted for subtract)
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             last_grant;

  logic             grant;
  logic             any_valid;
  logic             accept;
  logic             last_nib;
  logic [CW+1:0]    base;     // bit offset of the current nibble

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b_eff;
  logic             sel_cin_eff;

  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic [3:0]       cla_s;
  logic             cla_cout;
  logic [WIDTH-1:0] sum_fin;

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that was not granted last time wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    req0_ready = (state == IDLE) && any_valid && !grant;
    req1_ready = (state == IDLE) && any_valid &&  grant;
    accept     = (state == IDLE) && any_valid;
  end

  // Operand selection for the winning requester, including the subtract
  // transform so the datapath only ever performs additions.
  always_comb begin
    sel_a       = grant ? req1_a : req0_a;
    sel_b_eff   = grant ? req1_b : req0_b;
    sel_cin_eff = grant ? req1_cin : req0_cin;
`ifdef CLA_SEQ_SUB_EN
    if (grant ? req1_sub : req0_sub) begin
      sel_b_eff   = ~(grant ? req1_b : req0_b);
      sel_cin_eff = 1'b1;
    end
`endif
  end

  // Nibble slice feeding the shared CLA. Cin comes only from the carry
  // flop, so each cycle contains exactly one 4-bit lookahead stage.
  always_comb begin
    base     = {cnt, 2'b00};
    cla_a    = a_q[base +: 4];
    cla_b    = b_q[base +: 4];
    last_nib = (cnt == CW'(NIB - 1));
    sum_fin  = sum_q;
    sum_fin[base +: 4] = cla_s;
  end

  hierarchical_CLA u_cla (
    .A    (cla_a),
    .B    (cla_b),
    .Cin  (carry),
    .S    (cla_s),
    .Cout (cla_cout)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_nib) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= sel_a;
            b_q        <= sel_b_eff;
            carry      <= sel_cin_eff;
            cnt        <= '0;
            id_q       <= grant;
            last_grant <= grant;
            sum_q      <= '0;
          end
        end
        RUN: begin
          sum_q <= sum_fin;
          carry <= cla_cout;
          cnt   <= cnt + 1'b1;
          if (last_nib) begin
            // Response payload is captured once and held through DONE.
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_fin;
            rsp_cout  <= cla_cout;
            rsp_ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum_fin[WIDTH-1] != a_q[WIDTH-1]);
            rsp_id    <= id_q;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_nibble_sequencer
//
// Self-checking bench for cla_nibble_sequencer (WIDTH=16). Expected results
// come from a plain integer-add model, are pushed to exp_q at acceptance
// and popped when the response appears. Subtract tests are compiled only
// when CLA_SEQ_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_cla_nibble_sequencer;
  localparam int W  = 16;
  localparam int EW = W + 3;   // {id, ovf, cout, sum}

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
`ifdef CLA_SEQ_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_sum;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef CLA_SEQ_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef CLA_SEQ_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .dbg_state  (dbg_state)
  );

  function automatic logic [EW-1:0] model(input logic id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin,
                                          input logic sub);
    logic [W-1:0] eb;
    logic         c;
    logic [W:0]   t;
    logic         ovf;
    eb  = sub ? ~b : b;
    c   = sub ? 1'b1 : cin;
    t   = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, c};
    ovf = (a[W-1] == eb[W-1]) && (t[W-1] != a[W-1]);
    return {id, ovf, t[W], t[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Raises valid on one port, waits (bounded) for ready, pushes the expected
  // result on acceptance, then drops valid and scrambles the operands.
  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, output logic ok);
    ok = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
`ifdef CLA_SEQ_SUB_EN
      req1_sub = sub;
`endif
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
`ifdef CLA_SEQ_SUB_EN
      req0_sub = sub;
`endif
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        exp_q.push_back(model(id, a, b, cin, sub));
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
  endtask

  // Counts edges until rsp_valid is seen (sampled #1 after each edge).
  task automatic wait_valid(output int cyc, output logic ok);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) begin
        cyc = i; ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b id=%b cout=%b ovf=%b sum=%h want all 0",
               rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum);
    end
    checks++;
    if (dbg_state !== 2'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got state=%0d r0=%b r1=%b want 0 0 0",
               dbg_state, req0_ready, req1_ready);
    end
  endtask

  task automatic test_single_add();
    logic ok, okv;
    int cyc;
    logic [EW-1:0] e;
    rsp_ready = 1'b1;
    send(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept got no accept want accept"); end
    wait_valid(cyc, okv);
    checks++;
    if (!okv || cyc != 4) begin
      failures++; $display("FAIL single_latency got %0d (seen=%b) want 4", cyc, okv);
    end
    if (okv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_id, rsp_ovf, rsp_cout, rsp_sum} !== e) begin
        failures++;
        $display("FAIL single_result got %h want %h", {rsp_id, rsp_ovf, rsp_cout, rsp_sum}, e);
      end
      checks++;
      if (rsp_sum !== 16'h2233 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0 || rsp_id !== 1'b0) begin
        failures++;
        $display("FAIL single_const got sum=%h c=%b o=%b id=%b want 2233 0 0 0",
                 rsp_sum, rsp_cout, rsp_ovf, rsp_id);
      end
    end
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 2'd0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release got state=%0d valid=%b want 0 0", dbg_state, rsp_valid);
    end
  endtask

  task automatic test_carry_ripple();
    logic ok, okv;
    int cyc;
    logic [W-1:0] ta [2] = '{16'hFFFF, 16'h7FFF};
    logic [W+1:0] tw [2] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}}; // {ovf,cout,sum}
    logic [EW-1:0] e;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(1'b0, ta[k], 16'h0001, 1'b0, 1'b0, ok);
      wait_valid(cyc, okv);
      checks++;
      if (!ok || !okv || exp_q.size() == 0) begin
        failures++; $display("FAIL ripple_timeout got ok=%b seen=%b want 1 1", ok, okv);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_ovf, rsp_cout, rsp_sum} !== e) begin
          failures++;
          $display("FAIL ripple_model got %h want %h", {rsp_id, rsp_ovf, rsp_cout, rsp_sum}, e);
        end
        checks++;
        if ({rsp_ovf, rsp_cout, rsp_sum} !== tw[k]) begin
          failures++;
          $display("FAIL ripple_const[%0d] got %h want %h", k, {rsp_ovf, rsp_cout, rsp_sum}, tw[k]);
        end
      end
      exp_q.delete();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int seen = 0;
    int both_ready = 0;
    logic [EW-1:0] e;
    logic ok;
    int cyc;
    logic okv;
    apply_reset();
    exp_q.delete();
    rsp_ready = 1'b1;
    req0_a = 16'h0102; req0_b = 16'h0304; req0_cin = 1'b0;
    req1_a = 16'hA000; req1_b = 16'h6001; req1_cin = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? model(1'b0, req0_a, req0_b, req0_cin, 1'b0)
                                   : model(1'b1, req1_a, req1_b, req1_cin, 1'b0));
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 80 && seen < 4; i++) begin
      @(posedge clk); #1;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) both_ready++;
      if (rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        seen++;
        if (seen == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        checks++;
        if ({rsp_id, rsp_ovf, rsp_cout, rsp_sum} !== e) begin
          failures++;
          $display("FAIL contention[%0d] got id=%b res=%h want id=%b res=%h", seen,
                   rsp_id, {rsp_ovf, rsp_cout, rsp_sum}, e[EW-1], e[EW-2:0]);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (seen != 4 || both_ready != 0) begin
      failures++;
      $display("FAIL contention_count got seen=%0d both_ready=%0d want 4 0", seen, both_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    // last grant was req1; a lone req1 must still be granted
    send(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, ok);
    wait_valid(cyc, okv);
    checks++;
    if (!ok || !okv || rsp_id !== 1'b1 || rsp_sum !== 16'h0030) begin
      failures++;
      $display("FAIL lone_req1 got ok=%b seen=%b id=%b sum=%h want 1 1 1 0030",
               ok, okv, rsp_id, rsp_sum);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic ok, okv;
    int cyc;
    logic [EW-1:0] e;
    rsp_ready = 1'b0;
    send(1'b1, 16'h4321, 16'h1111, 1'b1, 1'b0, ok);
    wait_valid(cyc, okv);
    checks++;
    if (!ok || !okv || exp_q.size() == 0) begin
      failures++; $display("FAIL bp_timeout got ok=%b seen=%b want 1 1", ok, okv);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      req1_valid = 1'b1; req0_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_ovf, rsp_cout, rsp_sum} !== e ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0 || dbg_state !== 2'd2) begin
          failures++;
          $display("FAIL bp_hold[%0d] got v=%b res=%h r0=%b r1=%b st=%0d want 1 %h 0 0 2", k,
                   rsp_valid, {rsp_id, rsp_ovf, rsp_cout, rsp_sum}, req0_ready, req1_ready,
                   dbg_state, e);
        end
        @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dbg_state !== 2'd0 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_release got state=%0d valid=%b want 0 0", dbg_state, rsp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic ok, okv;
    int cyc;
    rsp_ready = 1'b1;
    send(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, ok);
    @(posedge clk); #2;             // inside the 2nd RUN cycle
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum} !== '0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL midrun_reset got v=%b id=%b c=%b o=%b sum=%h st=%0d want all 0",
               rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum, dbg_state);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, ok);
    wait_valid(cyc, okv);
    checks++;
    if (!ok || !okv || rsp_sum !== 16'h0007 || rsp_id !== 1'b0 || cyc != 4) begin
      failures++;
      $display("FAIL midrun_next got ok=%b seen=%b sum=%h id=%b lat=%0d want 1 1 0007 0 4",
               ok, okv, rsp_sum, rsp_id, cyc);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic ok, okv;
    int cyc;
    logic [EW-1:0] e;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'b0, ok);
      wait_valid(cyc, okv);
      checks++;
      if (!ok || !okv || exp_q.size() == 0) begin
        failures++; $display("FAIL random_timeout[%0d] got ok=%b seen=%b want 1 1", k, ok, okv);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_ovf, rsp_cout, rsp_sum} !== e) begin
          failures++;
          $display("FAIL random[%0d] got %h want %h", k, {rsp_id, rsp_ovf, rsp_cout, rsp_sum}, e);
        end
      end
      exp_q.delete();
      @(posedge clk); #1;
    end
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_subtract();
    logic ok, okv;
    int cyc;
    logic [W-1:0] sa [2] = '{16'h0005, 16'h0007};
    logic [W-1:0] sb [2] = '{16'h0007, 16'h0005};
    logic [W:0]   sw [2] = '{{1'b0, 16'hFFFE}, {1'b1, 16'h0002}};
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(1'b0, sa[k], sb[k], 1'b0, 1'b1, ok);
      wait_valid(cyc, okv);
      checks++;
      if (!ok || !okv || {rsp_cout, rsp_sum} !== sw[k]) begin
        failures++;
        $display("FAIL subtract[%0d] got ok=%b seen=%b res=%h want 1 1 %h",
                 k, ok, okv, {rsp_cout, rsp_sum}, sw[k]);
      end
      exp_q.delete();
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif
    rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_carry_ripple();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_random();
`ifdef CLA_SEQ_SUB_EN
    test_subtract();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide adder controller that shares one 4-bit carry-lookahead adder (`hierarchical_CLA`: A, B, Cin → S, Cout) between two requesters. It arbitrates round-robin and latches the winning WIDTH-bit operands. It then steps them through the CLA one nibble per cycle, LSB nibble first, with a registered inter-nibble carry, and returns the full sum on a valid/ready response port. It sits between requesting datapath blocks and the single shared CLA instance, which it instantiates internally.

## Interface
- `WIDTH`, 16, operand/sum width; multiple of 4, ≥ 4. NIB = WIDTH/4.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `req0_valid` / `req1_valid` input 1 — requester has an operation pending.
- `req0_ready` / `req1_ready` output 1 — operation accepted on the edge where valid & ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input WIDTH — operands.
- `req0_cin` / `req1_cin` input 1 — carry-in.
- `rsp_valid` output 1 — result available.
- `rsp_ready` input 1 — consumer takes the result.
- `rsp_id` output 1 — requester that owns the result.
- `rsp_sum` output WIDTH — sum.
- `rsp_cout` output 1 — carry out of bit WIDTH-1.
- `rsp_ovf` output 1 — signed overflow: operand MSBs equal and sum MSB differs; uses the effective B.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the one not in `last_grant`.
  - `reqN_ready` = IDLE & grant==N, combinational; at most one is high.
  - On handshake: latch a, b, cin and id; set `carry`=cin, `cnt`=0, `last_grant`=id; go to RUN.
- **RUN**
  - The CLA sees A=a[4·cnt+3:4·cnt], B=b[4·cnt+3:4·cnt], Cin=`carry`.
  - Each edge: write S into `sum` nibble cnt, `carry`←Cout, `cnt`++.
  - On the edge with cnt==NIB-1, go to DONE.
- **DONE**
  - `rsp_valid`=1. The sum, cout, ovf and id outputs are registered and held stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
- Requests are never accepted outside IDLE. Input operands may change freely after acceptance.
- `rsp_cout` = final `carry`.
- Reset values: state IDLE, `rsp_valid` 0, `rsp_sum` 0, `rsp_cout` 0, `rsp_ovf` 0, `rsp_id` 0, `cnt` 0, `carry` 0, `last_grant` 1 (req0 wins the first contention).
- Reset mid-operation aborts the operation immediately. The in-flight result is discarded and never presented.

## Timing
- Accept edge E0 → RUN occupies edges E1..E_NIB → `rsp_valid` high from the cycle after E_NIB.
  - Latency is NIB cycles from acceptance (4 for WIDTH=16).
  - WIDTH=4 gives 1 cycle.
- `rsp_ready` is sampled only in DONE. If it is already high, the handshake completes on the first DONE edge.
- A new request can be accepted no earlier than the cycle after the response handshake: peak throughput is one operation per NIB+2 cycles.
- A requester that deasserts valid before ready is simply not granted. No state is kept.
- The inter-nibble carry passes only through the `carry` flop. There is no combinational path from one nibble's Cout to the next nibble's Cin within a cycle.

## Configuration
- `CLA_SEQ_SUB_EN` defined:
  - Adds `req0_sub` / `req1_sub` (input 1), latched with the operands.
  - When sub=1: effective B = ~b, initial `carry` = 1, reqN_cin ignored. The result is a − b; `rsp_cout`=1 means no borrow.
  - `rsp_ovf` uses the effective B.
- Not defined: sub ports absent; addition only.

## Test plan
- Single add, WIDTH=16: req0 a=0x1234, b=0x0FFF, cin=0 → `rsp_sum`=0x2233, cout=0, ovf=0, id=0; `rsp_valid` exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum 0x0000, cout=1. Also a=0x7FFF, b=0x0001 → sum 0x8000, ovf=1, cout=0.
- Contention: both valid continuously from reset with rsp_ready=1 → ids served 0,1,0,1. A lone req1 is granted regardless of `last_grant`.
- Backpressure: `rsp_ready` held low 3 cycles in DONE → sum/id/cout stable, both reqN_ready low, no new accept. Release → IDLE next cycle.
- Reset mid-RUN: assert rst during the 2nd RUN cycle → `rsp_valid` and all outputs 0 immediately. The next request a=0x0003, b=0x0004 returns 0x0007.
- `CLA_SEQ_SUB_EN`: a=0x0005, b=0x0007, sub=1 → sum 0xFFFE, cout=0. Then a=0x0007, b=0x0005 → sum 0x0002, cout=1.
